// File: rtl/gray2rgb_serializer.sv
// gray2rgb_serializer: accepts one gray pixel per sink handshake and replays it
// as three byte-serial colour components (R, G, B) on the source stream.
// Optional build macro: G2R_PIXCNT_EN adds a per-frame pixel counter output
// (pix_count_o) and its width parameter PIX_CNT_W.
module gray2rgb_serializer #(
    parameter int COLOR_SIZE = 8
`ifdef G2R_PIXCNT_EN
    , parameter int PIX_CNT_W = 16
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [COLOR_SIZE-1:0] in_data_i,
    input  logic                  in_sop_i,
    input  logic                  in_eop_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [COLOR_SIZE-1:0] out_data_o,
    output logic [1:0]            out_chan_o,
    output logic                  out_sop_o,
    output logic                  out_eop_o
`ifdef G2R_PIXCNT_EN
    , output logic [PIX_CNT_W-1:0] pix_count_o
`endif
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_chan;
    logic [1:0]            w_chan_nxt;
    logic [COLOR_SIZE-1:0] r_pix;
    logic [COLOR_SIZE-1:0] w_pix_nxt;
    logic                  r_sop;
    logic                  w_sop_nxt;
    logic                  r_eop;
    logic                  w_eop_nxt;

    logic                  w_emit;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_accept;

    assign w_emit      = (r_state == S_EMIT);
    assign w_beat      = w_emit && out_ready_i;
    assign w_last_beat = w_beat && (r_chan == 2'd2);
    // The B beat completing frees the pixel register in the same cycle, so the
    // sink may refill it without a bubble (combinational from out_ready_i).
    assign in_ready_o  = (r_state == S_IDLE) || w_last_beat;
    assign w_accept    = in_valid_i && in_ready_o;

    assign out_valid_o = w_emit;
    assign out_data_o  = w_emit ? r_pix : '0;
    assign out_chan_o  = r_chan;
    assign out_sop_o   = w_emit && r_sop && (r_chan == 2'd0);
    assign out_eop_o   = w_emit && r_eop && (r_chan == 2'd2);

    // Next-state and pixel-register update: latch on accept, step channel per beat.
    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_pix_nxt   = r_pix;
        w_sop_nxt   = r_sop;
        w_eop_nxt   = r_eop;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_pix_nxt   = in_data_i;
                    w_sop_nxt   = in_sop_i;
                    w_eop_nxt   = in_eop_i;
                    w_chan_nxt  = 2'd0;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_beat) begin
                    if (r_chan != 2'd2) begin
                        w_chan_nxt = r_chan + 2'd1;
                    end else if (w_accept) begin
                        w_pix_nxt  = in_data_i;
                        w_sop_nxt  = in_sop_i;
                        w_eop_nxt  = in_eop_i;
                        w_chan_nxt = 2'd0;
                    end else begin
                        w_chan_nxt  = 2'd0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_chan_nxt  = 2'd0;
            end
        endcase
    end

    // State and pixel registers with async reset and synchronous soft clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_chan  <= 2'd0;
            r_pix   <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else if (clear_i) begin
            r_state <= S_IDLE;
            r_chan  <= 2'd0;
            r_pix   <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_chan  <= w_chan_nxt;
            r_pix   <= w_pix_nxt;
            r_sop   <= w_sop_nxt;
            r_eop   <= w_eop_nxt;
        end
    end

`ifdef G2R_PIXCNT_EN
    logic [PIX_CNT_W-1:0] r_pix_cnt;

    assign pix_count_o = r_pix_cnt;

    // Pixel counter: restarts at 1 on a frame's first pixel, else counts B beats.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pix_cnt <= '0;
        end else if (clear_i) begin
            r_pix_cnt <= '0;
        end else if (w_last_beat) begin
            r_pix_cnt <= r_sop ? PIX_CNT_W'(1) : r_pix_cnt + PIX_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gray2rgb_serializer.sv
// Randomised self-checking bench for gray2rgb_serializer. The reference model
// is a queue of pending output beats: each accepted pixel pushes its R, G, B
// beats; each completed output beat pops the head.
module tb_gray2rgb_serializer;

    localparam int CW  = 8;
`ifdef G2R_PIXCNT_EN
    localparam int PCW = 3;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [CW-1:0] in_data_i = '0;
    logic          in_sop_i = 1'b0;
    logic          in_eop_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] out_data_o;
    logic [1:0]    out_chan_o;
    logic          out_sop_o;
    logic          out_eop_o;
`ifdef G2R_PIXCNT_EN
    logic [PCW-1:0] pix_count_o;
`endif

    always #5 clk_i = ~clk_i;

`ifdef G2R_PIXCNT_EN
    gray2rgb_serializer #(.COLOR_SIZE(CW), .PIX_CNT_W(PCW)) dut (
`else
    gray2rgb_serializer #(.COLOR_SIZE(CW)) dut (
`endif
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_sop_i    (in_sop_i),
        .in_eop_i    (in_eop_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_chan_o  (out_chan_o),
        .out_sop_o   (out_sop_o),
        .out_eop_o   (out_eop_o)
`ifdef G2R_PIXCNT_EN
        , .pix_count_o (pix_count_o)
`endif
    );

    typedef struct {
        logic [CW-1:0] d;
        logic [1:0]    ch;
        logic          sop;
        logic          eop;
        logic          psop;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_beats = 0;
    int    cnt     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_pixel(input logic [CW-1:0] d, input logic s, input logic e);
        for (int c = 0; c < 3; c++) begin
            beat_t b;
            b.d    = d;
            b.ch   = 2'(c);
            b.sop  = s && (c == 0);
            b.eop  = e && (c == 2);
            b.psop = s;
            q.push_back(b);
        end
    endtask

    task automatic flush_model();
        q.delete();
        cnt = 0;
    endtask

    task automatic check_outputs(input logic ordy);
        logic exp_valid;
        logic exp_rdy;
        exp_valid = (q.size() > 0);
        exp_rdy   = (q.size() == 0) || ((q.size() == 1) && ordy);
        check_eq("out_valid", 32'(out_valid_o), 32'(exp_valid));
        check_eq("in_ready", 32'(in_ready_o), 32'(exp_rdy));
        if (exp_valid) begin
            check_eq("out_data", 32'(out_data_o), 32'(q[0].d));
            check_eq("out_chan", 32'(out_chan_o), 32'(q[0].ch));
            check_eq("out_sop", 32'(out_sop_o), 32'(q[0].sop));
            check_eq("out_eop", 32'(out_eop_o), 32'(q[0].eop));
        end else begin
            check_eq("idle_data", 32'(out_data_o), 32'h0);
            check_eq("idle_sop", 32'(out_sop_o), 32'h0);
            check_eq("idle_eop", 32'(out_eop_o), 32'h0);
        end
`ifdef G2R_PIXCNT_EN
        check_eq("pix_count", 32'(pix_count_o), 32'(cnt));
`endif
    endtask

    // One clock cycle: drive at negedge, check mid-low-phase, update model after posedge.
    task automatic step(input logic v, input logic [CW-1:0] d, input logic s, input logic e,
                        input logic ordy, input logic clr, output logic accepted);
        logic out_f;
        logic in_f;
        @(negedge clk_i);
        in_valid_i  = v;
        in_data_i   = d;
        in_sop_i    = s;
        in_eop_i    = e;
        out_ready_i = ordy;
        clear_i     = clr;
        #2;
        check_outputs(ordy);
        out_f = (q.size() > 0) && ordy;
        in_f  = v && ((q.size() == 0) || ((q.size() == 1) && ordy));
        @(posedge clk_i);
        accepted = in_f && !clr;
        if (clr) begin
            flush_model();
        end else begin
            if (out_f) begin
                beat_t b;
                b = q.pop_front();
                n_beats++;
                if (b.ch == 2'd2) cnt = b.psop ? 1 : cnt + 1;
`ifdef G2R_PIXCNT_EN
                cnt = cnt & ((1 << PCW) - 1);
`endif
            end
            if (in_f) push_pixel(d, s, e);
        end
    endtask

    task automatic idle_cycles(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, a);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic           acc;
        int             start;
        int             idx;
        logic [CW-1:0]  pix[4];
        logic [3:0]     bp_pat;

        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Reset state and single sop+eop pixel.
        idle_cycles(1);
        start = n_beats;
        step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        check_eq("single_accept", 32'(acc), 32'h1);
        idle_cycles(5);
        check_eq("single_beats", 32'(n_beats - start), 32'd3);

        // Back-to-back stream of four pixels.
        pix[0] = 8'h10; pix[1] = 8'h20; pix[2] = 8'h30; pix[3] = 8'h40;
        start = n_beats;
        idx = 0;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            step(1'b1, pix[idx], idx == 0, idx == 3, 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        check_eq("b2b_accepted", 32'(idx), 32'd4);
        idle_cycles(12);
        check_eq("b2b_beats", 32'(n_beats - start), 32'd12);

        // Backpressure with out_ready pattern 1,0,0,1 repeating.
        start = n_beats;
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        bp_pat = 4'b1001;
        for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b0, 1'b0, bp_pat[k % 4], 1'b0, acc);
        check_eq("bp_beats", 32'(n_beats - start), 32'd3);

        // Asynchronous reset after the G beat.
        step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid_o), 32'h0);
        check_eq("rst_data", 32'(out_data_o), 32'h0);
        check_eq("rst_chan", 32'(out_chan_o), 32'h0);
        check_eq("rst_eop", 32'(out_eop_o), 32'h0);
        check_eq("rst_ready", 32'(in_ready_o), 32'h1);
        flush_model();
        @(negedge clk_i);
        rst_i = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        idle_cycles(4);

        // Synchronous clear while emitting.
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        idle_cycles(3);

        // Pixel-count frame: five pixels then a new sop pixel.
        idx = 0;
        for (int i = 0; i < 40 && idx < 6; i++) begin
            step(1'b1, 8'(8'h60 + idx), (idx == 0) || (idx == 5), idx == 4, 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        idle_cycles(4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) == 0, acc);
        end
        idle_cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
